ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Parametrised successor to the single-word ISA decoder. Drops the one-shot external `value` capture in favour of a self-sequencing fetch/decode/issue controller. It owns a program counter, reads instruction words from a synchronous program memory, decodes them into ALU op codes plus operand addresses, and hands each op to the ALU over a valid/ready handshake. It sits between the program memory and the ALU/register-file line controller.

## Interface
Parameters:
- `ADDRESS_BITS`, 5: operand address field width; low bits of the instruction word.
- `INSTR_BITS`, 3: opcode field width; bits directly above the address field. Must be ≥ 3.
- `PC_BITS`, 8: program counter width.
- `VALUE_BITS` (localparam): `INSTR_BITS + ADDRESS_BITS`.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: start request; sampled in IDLE only.
- `i_mem_data` in VALUE_BITS: instruction word; valid the cycle after `o_mem_rd`.
- `o_pc` out PC_BITS: program memory read address.
- `o_mem_rd` out 1: program memory read strobe.
- `o_address` out ADDRESS_BITS: operand address for the ALU line.
- `o_instr` out 8: ALU op code.
- `o_valid` out 1: `o_instr`/`o_address` hold a pending op.
- `i_ready` in 1: ALU accepts the op when high together with `o_valid`.
- `o_halted` out 1: HALT executed.
- `o_err` out 1: sticky; an illegal opcode was seen.

## Operation
- Opcode = `i_mem_data[VALUE_BITS-1:ADDRESS_BITS]`. Only the low 3 bits are decoded. Any nonzero upper opcode bit makes the opcode illegal.
- Decode map:
  - 000 NOP: no issue.
  - 001 LD: ALU 8'h00.
  - 010 ADD: ALU 8'h02.
  - 100 STO: ALU 8'h01.
  - 011 JMP: only with the config macro.
  - 111 HALT.
  - All others are illegal.
- `o_instr` idles at 8'hFF whenever `o_valid` = 0.
- States:
  - IDLE: `enable` = 1 goes to FETCH.
  - FETCH: drive `o_pc`, pulse `o_mem_rd`, then go to DECODE.
  - DECODE: capture `i_mem_data` and branch by opcode:
    - LD/ADD/STO: go to ISSUE.
    - NOP or illegal: pc += 1, go to FETCH.
    - JMP: load pc, go to FETCH.
    - HALT: go to HALTED.
  - ISSUE: `o_valid` = 1, with `o_instr`/`o_address` held stable. On `o_valid & i_ready`: pc += 1, go to FETCH.
  - HALTED: `o_halted` = 1. Exit only via `rst`.
- Illegal opcode sets `o_err`; it stays set until `rst`. The illegal word is otherwise executed as a NOP.
- PC arithmetic is modulo 2^PC_BITS: pc = 2^PC_BITS−1 plus 1 wraps to 0.
- `enable` is ignored outside IDLE. Holding it high does not restart the controller.

## Timing
- Reset values at the first edge with `rst` = 1:
  - state IDLE, pc 0.
  - `o_pc` 0, `o_mem_rd` 0, `o_address` 0, `o_instr` 8'hFF.
  - `o_valid` 0, `o_halted` 0, `o_err` 0.
- Reset has priority over every other event, including a handshake in the same cycle.
- Reset during ISSUE drops `o_valid` at that edge; the op counts as not accepted.
- Latency:
  - `enable` sampled in IDLE puts `o_mem_rd` high in the next cycle.
  - `o_valid` rises 2 cycles after the FETCH cycle.
  - Issued ops cost 3 cycles each with `i_ready` held high.
  - NOP, illegal and JMP cost 2 cycles each.
- Handshake: while `o_valid` = 1 and `i_ready` = 0, all outputs hold. `o_valid` deasserts in the cycle after acceptance.
- All outputs are registered; no combinational path from `i_ready` or `i_mem_data` to any output.

## Configuration
- `CTRL_JMP_EN` defined:
  - 011 JMP loads pc with the address field. The field is zero-extended to PC_BITS when PC_BITS > ADDRESS_BITS, else truncated to the low PC_BITS bits.
  - No ALU issue; `o_err` is unaffected.
- `CTRL_JMP_EN` undefined: 011 is illegal; it sets `o_err` and executes as a NOP.

## Test plan
- Program LD 3, ADD 4, STO 5, HALT (8'h23, 8'h44, 8'h85, 8'hE0), `i_ready` = 1.
  - Ops issued: (00,3), (02,4), (01,5).
  - `o_halted` = 1 at cycle 12 after `enable`; `o_pc` = 3.
- ADD with `i_ready` low for 4 cycles:
  - `o_valid`, `o_instr` = 02 and `o_address` stable for 5 cycles.
  - Exactly one acceptance; pc advances by 1.
- Word 8'hA0 (opcode 101):
  - `o_err` = 1 and stays set.
  - No `o_valid` pulse; pc increments.
- JMP 0 (8'h60) at pc 2:
  - With `CTRL_JMP_EN`: next `o_pc` = 0, `o_err` = 0.
  - Without it: `o_pc` = 3, `o_err` = 1.
- PC_BITS = 3, eight NOPs: after pc 7, `o_pc` wraps to 0.
- `rst` asserted while `o_valid` = 1 and `i_ready` = 1:
  - Next cycle shows all reset values.
  - No pc increment; `enable` restarts from pc 0.

Source files
------------

// File: rtl/ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_seq
// Purpose  : Self-sequencing fetch/decode/issue controller. Owns a program
//            counter, reads instruction words from a synchronous program
//            memory, decodes them into ALU op codes plus operand addresses
//            and hands each op to the ALU over a valid/ready handshake.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            enable          - start request (looked at in IDLE only)
//            i_mem_data      - instruction word, valid the cycle after o_mem_rd
//            o_pc, o_mem_rd  - program memory read address / read strobe
//            o_address       - operand address for the ALU line
//            o_instr         - ALU op code (8'hFF while o_valid is low)
//            o_valid,i_ready - op handshake towards the ALU
//            o_halted        - HALT executed
//            o_err           - sticky illegal-opcode flag
// Options  : CTRL_JMP_EN     - when defined, opcode 011 is a JMP that loads
//                              the pc from the address field; otherwise 011
//                              is illegal.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_seq #(
   parameter int ADDRESS_BITS = 5,
   parameter int INSTR_BITS   = 3,
   parameter int PC_BITS      = 8,
   localparam int VALUE_BITS  = INSTR_BITS + ADDRESS_BITS
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [VALUE_BITS-1:0]   i_mem_data,
   output logic [PC_BITS-1:0]      o_pc,
   output logic                    o_mem_rd,
   output logic [ADDRESS_BITS-1:0] o_address,
   output logic [7:0]              o_instr,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic                    o_halted,
   output logic                    o_err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      ISSUE  = 3'd3,
      HALTED = 3'd4
   } state_t;

   localparam logic [7:0] ALU_LD   = 8'h00;
   localparam logic [7:0] ALU_STO  = 8'h01;
   localparam logic [7:0] ALU_ADD  = 8'h02;
   localparam logic [7:0] ALU_IDLE = 8'hFF;

   state_t                  state_q, state_d;
   logic [PC_BITS-1:0]      pc_q, pc_d;
   logic                    mem_rd_q, mem_rd_d;
   logic [ADDRESS_BITS-1:0] address_q, address_d;
   logic [7:0]              instr_q, instr_d;
   logic                    valid_q, valid_d;
   logic                    halted_q, halted_d;
   logic                    err_q, err_d;

   logic [INSTR_BITS-1:0]   opcode;
   logic [ADDRESS_BITS-1:0] addr_field;
   logic                    upper_nz;

   assign opcode     = i_mem_data[VALUE_BITS-1:ADDRESS_BITS];
   assign addr_field = i_mem_data[ADDRESS_BITS-1:0];
   // Only the low three opcode bits carry meaning; anything above them
   // being set makes the word illegal.
   assign upper_nz   = (opcode >> 3) != '0;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      address_d = address_q;
      instr_d   = instr_q;
      err_d     = err_q;

      unique case (state_q)
         IDLE: begin
            if (enable) state_d = FETCH;
         end
         FETCH: begin
            state_d = DECODE;
         end
         DECODE: begin
            // Default path covers NOP and every illegal word.
            state_d = FETCH;
            pc_d    = pc_q + PC_BITS'(1);
            if (upper_nz) begin
               err_d = 1'b1;
            end else begin
               case (opcode[2:0])
                  3'b000: ;
                  3'b001: begin
                     state_d   = ISSUE;
                     pc_d      = pc_q;
                     instr_d   = ALU_LD;
                     address_d = addr_field;
                  end
                  3'b010: begin
                     state_d   = ISSUE;
                     pc_d      = pc_q;
                     instr_d   = ALU_ADD;
                     address_d = addr_field;
                  end
                  3'b100: begin
                     state_d   = ISSUE;
                     pc_d      = pc_q;
                     instr_d   = ALU_STO;
                     address_d = addr_field;
                  end
`ifdef CTRL_JMP_EN
                  // Size cast zero-extends or truncates as PC_BITS demands.
                  3'b011: pc_d = PC_BITS'(addr_field);
`endif
                  3'b111: begin
                     state_d = HALTED;
                     pc_d    = pc_q;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         ISSUE: begin
            if (i_ready) begin
               state_d = FETCH;
               pc_d    = pc_q + PC_BITS'(1);
               instr_d = ALU_IDLE;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Strobes are registered from the next state so each one is high
      // exactly during the cycle spent in its state.
      mem_rd_d = (state_d == FETCH);
      valid_d  = (state_d == ISSUE);
      halted_d = (state_d == HALTED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         mem_rd_q  <= 1'b0;
         address_q <= '0;
         instr_q   <= ALU_IDLE;
         valid_q   <= 1'b0;
         halted_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         mem_rd_q  <= mem_rd_d;
         address_q <= address_d;
         instr_q   <= instr_d;
         valid_q   <= valid_d;
         halted_q  <= halted_d;
         err_q     <= err_d;
      end
   end

   assign o_pc      = pc_q;
   assign o_mem_rd  = mem_rd_q;
   assign o_address = address_q;
   assign o_instr   = instr_q;
   assign o_valid   = valid_q;
   assign o_halted  = halted_q;
   assign o_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_seq
// Purpose  : Directed self-checking bench for ctrl_seq with a synchronous
//            program memory model and an acceptance monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_seq;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [7:0] i_mem_data;
   logic [7:0] o_pc;
   logic       o_mem_rd;
   logic [4:0] o_address;
   logic [7:0] o_instr;
   logic       o_valid;
   logic       i_ready;
   logic       o_halted;
   logic       o_err;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  mem [256];
   logic [12:0] acc_q [$];

   ctrl_seq #(
      .ADDRESS_BITS(5),
      .INSTR_BITS  (3),
      .PC_BITS     (8)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .i_mem_data(i_mem_data),
      .o_pc      (o_pc),
      .o_mem_rd  (o_mem_rd),
      .o_address (o_address),
      .o_instr   (o_instr),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_halted  (o_halted),
      .o_err     (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous program memory: data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (o_mem_rd) i_mem_data <= mem[o_pc];
   end

   // Record every accepted op as {instr, address}.
   always @(posedge clk) begin
      if (!rst && o_valid && i_ready) acc_q.push_back({o_instr, o_address});
   end

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input logic [7:0] v);
      for (int a = 0; a < 256; a++) mem[a] = v;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      enable = 1'b0;
      step(1);
      rst    = 1'b0;
      acc_q.delete();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pc"},     32'(o_pc),      32'h0);
      chk({tag, "_rd"},     32'(o_mem_rd),  32'h0);
      chk({tag, "_addr"},   32'(o_address), 32'h0);
      chk({tag, "_instr"},  32'(o_instr),   32'hFF);
      chk({tag, "_valid"},  32'(o_valid),   32'h0);
      chk({tag, "_halted"}, 32'(o_halted),  32'h0);
      chk({tag, "_err"},    32'(o_err),     32'h0);
   endtask

   initial begin
      rst        = 1'b1;
      enable     = 1'b0;
      i_ready    = 1'b0;
      i_mem_data = 8'h00;
      fill(8'hE0);

      // ---------------- reset state ----------------
      step(1);
      chk_reset_vals("rst0");
      rst = 1'b0;

      // ---------------- LD 3, ADD 4, STO 5, HALT ----------------
      fill(8'hE0);
      mem[0] = 8'h23; mem[1] = 8'h44; mem[2] = 8'h85; mem[3] = 8'hE0;
      i_ready = 1'b1;
      acc_q.delete();
      enable = 1'b1;           // held high throughout: must not restart
      step(1);                 // cycle 1: FETCH
      chk("p1_rd_c1", 32'(o_mem_rd), 32'h1);
      chk("p1_pc_c1", 32'(o_pc), 32'h0);
      for (int c = 2; c <= 12; c++) begin
         step(1);
         if (c == 3) begin
            chk("p1_valid_c3", 32'(o_valid), 32'h1);
            chk("p1_instr_c3", 32'(o_instr), 32'h00);
            chk("p1_addr_c3",  32'(o_address), 32'h3);
         end
         if (c == 11) chk("p1_halted_c11", 32'(o_halted), 32'h0);
      end
      chk("p1_halted_c12", 32'(o_halted), 32'h1);
      chk("p1_pc_halt", 32'(o_pc), 32'h3);
      chk("p1_n_acc", 32'(acc_q.size()), 32'h3);
      if (acc_q.size() == 3) begin
         chk("p1_acc0", 32'(acc_q[0]), 32'({8'h00, 5'd3}));
         chk("p1_acc1", 32'(acc_q[1]), 32'({8'h02, 5'd4}));
         chk("p1_acc2", 32'(acc_q[2]), 32'({8'h01, 5'd5}));
      end
      step(3);
      chk("p1_still_halted", 32'(o_halted), 32'h1);
      chk("p1_no_rd", 32'(o_mem_rd), 32'h0);
      chk("p1_err", 32'(o_err), 32'h0);

      // ---------------- ADD stalled by i_ready ----------------
      do_reset();
      fill(8'hE0);
      mem[0] = 8'h44;
      i_ready = 1'b0;
      enable  = 1'b1;
      step(1);                 // FETCH
      enable  = 1'b0;
      step(2);                 // DECODE, then first ISSUE cycle
      for (int s = 1; s <= 5; s++) begin
         if (s == 5) i_ready = 1'b1;
         chk($sformatf("p2_valid_s%0d", s), 32'(o_valid), 32'h1);
         chk($sformatf("p2_instr_s%0d", s), 32'(o_instr), 32'h02);
         chk($sformatf("p2_addr_s%0d", s),  32'(o_address), 32'h4);
         chk($sformatf("p2_pc_s%0d", s),    32'(o_pc), 32'h0);
         step(1);
      end
      chk("p2_valid_after", 32'(o_valid), 32'h0);
      chk("p2_instr_after", 32'(o_instr), 32'hFF);
      chk("p2_pc_after", 32'(o_pc), 32'h1);
      chk("p2_n_acc", 32'(acc_q.size()), 32'h1);

      // ---------------- illegal opcode 101 ----------------
      do_reset();
      fill(8'hE0);
      mem[0] = 8'hA0;
      i_ready = 1'b1;
      enable  = 1'b1;
      step(1);
      enable  = 1'b0;
      step(1);                 // DECODE
      chk("p3_valid_dec", 32'(o_valid), 32'h0);
      step(1);                 // next FETCH
      chk("p3_err", 32'(o_err), 32'h1);
      chk("p3_valid", 32'(o_valid), 32'h0);
      chk("p3_pc", 32'(o_pc), 32'h1);
      step(2);
      chk("p3_err_sticky", 32'(o_err), 32'h1);
      chk("p3_halted", 32'(o_halted), 32'h1);
      chk("p3_n_acc", 32'(acc_q.size()), 32'h0);

      // ---------------- JMP 0 at pc 2 ----------------
      do_reset();
      fill(8'hE0);
      mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h60;
      enable = 1'b1;
      step(1);
      enable = 1'b0;
      step(6);                 // F0 D0 F1 D1 F2 D2 -> now FETCH after the JMP
`ifdef CTRL_JMP_EN
      chk("p4_pc", 32'(o_pc), 32'h0);
      chk("p4_err", 32'(o_err), 32'h0);
`else
      chk("p4_pc", 32'(o_pc), 32'h3);
      chk("p4_err", 32'(o_err), 32'h1);
`endif
      chk("p4_rd", 32'(o_mem_rd), 32'h1);
      chk("p4_n_acc", 32'(acc_q.size()), 32'h0);

      // ---------------- PC wrap over a NOP-only program ----------------
      do_reset();
      fill(8'h00);
      enable = 1'b1;
      step(1);                 // cycle 1: FETCH pc 0
      enable = 1'b0;
      step(510);               // cycle 511: FETCH pc 255
      chk("p5_pc_max", 32'(o_pc), 32'hFF);
      chk("p5_rd_max", 32'(o_mem_rd), 32'h1);
      step(2);                 // cycle 513: FETCH pc 0
      chk("p5_pc_wrap", 32'(o_pc), 32'h0);
      chk("p5_rd_wrap", 32'(o_mem_rd), 32'h1);
      chk("p5_err", 32'(o_err), 32'h0);

      // ---------------- reset during ISSUE with i_ready high ----------------
      do_reset();
      fill(8'hE0);
      mem[0] = 8'h23;
      i_ready = 1'b1;
      enable  = 1'b1;
      step(1);
      enable  = 1'b0;
      step(2);                 // ISSUE
      chk("p6_valid_pre", 32'(o_valid), 32'h1);
      rst = 1'b1;
      step(1);
      chk_reset_vals("p6");
      chk("p6_n_acc", 32'(acc_q.size()), 32'h0);
      rst    = 1'b0;
      enable = 1'b1;
      step(1);
      chk("p6_restart_pc", 32'(o_pc), 32'h0);
      chk("p6_restart_rd", 32'(o_mem_rd), 32'h1);
      enable = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
